// File: rtl/ser_pkg.sv
// Shared helpers for the bit-serial pipeline (to_serial / from_serial):
// digit-count arithmetic, parameter legality check and lane control strobes.
package ser_pkg;

    typedef struct packed {
        logic shift;       // ordinary digit: shift into sr
        logic load_first;  // realign + digit: digit 0 of a new word
        logic complete;    // last digit: publish the word
        logic clear;       // realign without digit: drop partial word
    } lane_ctl_t;

    function automatic int unsigned ser_cyc(input int unsigned bw_out, input int unsigned bw_in);
        return bw_out / bw_in;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned sc);
        return (sc <= 1) ? 1 : $clog2(sc);
    endfunction

    function automatic bit params_ok(input int unsigned bw_out, input int unsigned bw_in);
        int unsigned sc;
        if (bw_in == 0 || bw_out < bw_in || (bw_out % bw_in) != 0) return 1'b0;
        sc = bw_out / bw_in;
        return (sc & (sc - 1)) == 0;
    endfunction

endpackage

// File: rtl/from_serial_if.sv
// Serial-in / parallel-out bundle of the deserialiser; master is the upstream side.
interface from_serial_if #(
    parameter int unsigned NO_CH  = 64,
    parameter int unsigned BW_IN  = 1,
    parameter int unsigned BW_OUT = 16
);
    logic                               vld_in;
    logic                               ser_rst;
    logic [NO_CH-1:0][BW_IN-1:0]        data_in;
    logic                               vld_out;
    logic [NO_CH-1:0][BW_OUT-1:0]       data_out;
    logic                               frame_err;

    modport master (
        output vld_in, ser_rst, data_in,
        input  vld_out, data_out, frame_err
    );

    modport slave (
        input  vld_in, ser_rst, data_in,
        output vld_out, data_out, frame_err
    );
endinterface

// File: rtl/from_serial_lane.sv
// One channel of the deserialiser: LSB-first shift register plus held output word.
module from_serial_lane
    import ser_pkg::*;
#(
    parameter int unsigned BW_IN  = 1,
    parameter int unsigned BW_OUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  lane_ctl_t         ctl,
    input  logic [BW_IN-1:0]  din,
    output logic [BW_OUT-1:0] dout
);

    if (BW_OUT == BW_IN) begin : g_direct
        logic unused_ctl;
        assign unused_ctl = ^{ctl.shift, ctl.load_first, ctl.clear};

        always_ff @(posedge clk or negedge rst) begin
            if (!rst)              dout <= '0;
            else if (ctl.complete) dout <= din;
        end
    end else begin : g_shift
        localparam int unsigned SR_W = BW_OUT - BW_IN;

        logic [SR_W-1:0] sr;
        logic [SR_W-1:0] src;

        // A realigning digit shifts into an empty register, not the stale partial word
        assign src = ctl.load_first ? '0 : sr;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sr   <= '0;
                dout <= '0;
            end else begin
                if (ctl.clear)
                    sr <= '0;
                else if (ctl.shift || ctl.load_first)
                    sr <= SR_W'({din, src} >> BW_IN);
                if (ctl.complete)
                    dout <= {din, sr};
            end
        end
    end

endmodule

// File: rtl/from_serial.sv
// Deserialiser: NO_CH lanes share one digit counter and rebuild BW_OUT-bit words
// from SER_CYC LSB-first BW_IN-bit digits; ser_rst realigns to a word boundary.
module from_serial
    import ser_pkg::*;
#(
    parameter int unsigned NO_CH  = 64,
    parameter int unsigned BW_IN  = 1,
    parameter int unsigned BW_OUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    from_serial_if.slave   bus
);

    localparam int unsigned SC = ser_cyc(BW_OUT, BW_IN);
    localparam int unsigned CW = cnt_w(SC);

    if (!params_ok(BW_OUT, BW_IN)) begin : g_bad_params
        $error("from_serial: BW_OUT must be a power-of-two multiple of BW_IN");
    end

    logic [CW-1:0]                 cnt;
    logic                          last;
    logic                          vld_q;
    logic                          ferr_q;
    lane_ctl_t                     ctl;
    logic [NO_CH-1:0][BW_OUT-1:0]  words;

    assign last = (cnt == CW'(SC - 1));

    always_comb begin
        ctl            = '0;
        ctl.clear      = bus.ser_rst && !bus.vld_in;
        ctl.load_first = bus.ser_rst && bus.vld_in;
        ctl.shift      = bus.vld_in && !bus.ser_rst;
        // After a realign the digit is digit 0, which only ends a word when SC==1
        ctl.complete   = bus.vld_in && (bus.ser_rst ? (SC == 1) : last);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            vld_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            vld_q  <= ctl.complete;
            ferr_q <= bus.ser_rst && (cnt != '0);
            if (bus.ser_rst)
                cnt <= (bus.vld_in && SC > 1) ? CW'(1) : '0;
            else if (bus.vld_in)
                cnt <= last ? '0 : cnt + CW'(1);
        end
    end

    for (genvar c = 0; c < NO_CH; c++) begin : g_lane
        from_serial_lane #(
            .BW_IN  (BW_IN),
            .BW_OUT (BW_OUT)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .ctl  (ctl),
            .din  (bus.data_in[c]),
            .dout (words[c])
        );
    end

    assign bus.data_out  = words;
    assign bus.vld_out   = vld_q;
    assign bus.frame_err = ferr_q;

endmodule

// File: tb/tb_from_serial.sv
// Scoreboard bench for from_serial: a 4x2->8 instance for framing scenarios and
// a 1x1->16 instance for long-word streaming.
module tb_from_serial;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    from_serial_if #(.NO_CH(4), .BW_IN(2), .BW_OUT(8))  ifa ();
    from_serial_if #(.NO_CH(1), .BW_IN(1), .BW_OUT(16)) ifb ();

    from_serial #(.NO_CH(4), .BW_IN(2), .BW_OUT(8)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa)
    );
    from_serial #(.NO_CH(1), .BW_IN(1), .BW_OUT(16)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb)
    );

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    logic [31:0] q_a[$];
    logic [15:0] q_b[$];
    int unsigned vld_a = 0, ferr_a = 0, vld_b = 0, ferr_b = 0;
    logic [31:0] prev_a = '0;
    logic [15:0] prev_b = '0;
    int          last_pulse_b = -1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor A: pop expected word on every pulse; data_out must not move otherwise
    always @(negedge clk) begin
        if (!rst) begin
            prev_a = ifa.data_out;
        end else begin
            if (ifa.vld_out) begin
                vld_a++;
                if (q_a.size() == 0) chk("a_unexpected_vld", 1, 0);
                else                 chk("a_data_out", ifa.data_out, q_a.pop_front());
            end else if (ifa.data_out !== prev_a) begin
                chk("a_data_out_stable", ifa.data_out, prev_a);
            end
            if (ifa.frame_err) ferr_a++;
            prev_a = ifa.data_out;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            prev_b = ifb.data_out;
        end else begin
            if (ifb.vld_out) begin
                vld_b++;
                if (q_b.size() == 0) chk("b_unexpected_vld", 1, 0);
                else                 chk("b_data_out", ifb.data_out, q_b.pop_front());
                if (last_pulse_b >= 0) chk("b_pulse_spacing", cyc - last_pulse_b, 16);
                last_pulse_b = cyc;
            end else if (ifb.data_out !== prev_b) begin
                chk("b_data_out_stable", ifb.data_out, prev_b);
            end
            if (ifb.frame_err) ferr_b++;
            prev_b = ifb.data_out;
        end
    end

    // Drives n_dig digits of the 4-channel word w (ch c at w[8c+:8]), gap idle cycles after each
    task automatic send_a(input logic [31:0] w, input int unsigned n_dig, input int unsigned gap,
                          input bit realign_first, input bit push);
        for (int unsigned d = 0; d < n_dig; d++) begin
            for (int unsigned c = 0; c < 4; c++) ifa.data_in[c] = w[c*8 + 2*d +: 2];
            ifa.vld_in  = 1'b1;
            ifa.ser_rst = realign_first && (d == 0);
            if (push && d == 3) q_a.push_back(w);
            step();
            ifa.vld_in  = 1'b0;
            ifa.ser_rst = 1'b0;
            repeat (gap) step();
        end
    endtask

    task automatic expect_pulses(input string tag, input int unsigned v0, input int unsigned f0,
                                 input int unsigned dv, input int unsigned df);
        step();
        step();
        chk({tag, "_vld_count"},  vld_a - v0,  dv);
        chk({tag, "_ferr_count"}, ferr_a - f0, df);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned v0, f0;
        logic [15:0] wb;

        ifa.vld_in = 1'b0; ifa.ser_rst = 1'b0; ifa.data_in = '0;
        ifb.vld_in = 1'b0; ifb.ser_rst = 1'b0; ifb.data_in = '0;
        repeat (3) step();
        chk("reset_data_out_a", ifa.data_out, 0);
        chk("reset_vld_out_a",  ifa.vld_out, 0);
        chk("reset_frame_err_a", ifa.frame_err, 0);
        chk("reset_data_out_b", ifb.data_out, 0);
        rst = 1'b1;
        step();

        // Basic back-to-back word, distinct pattern per channel
        v0 = vld_a; f0 = ferr_a;
        send_a(32'h3C00FFA5, 4, 0, 1'b0, 1'b1);
        expect_pulses("basic", v0, f0, 1, 0);

        // Same digits with idle gaps
        v0 = vld_a; f0 = ferr_a;
        send_a(32'h3C00FFA5, 4, 3, 1'b0, 1'b1);
        expect_pulses("gapped", v0, f0, 1, 0);

        // Realign alone after 2 digits
        v0 = vld_a; f0 = ferr_a;
        send_a(32'h3C00FFA5, 2, 0, 1'b0, 1'b0);
        ifa.ser_rst = 1'b1;
        step();
        ifa.ser_rst = 1'b0;
        expect_pulses("realign", v0, f0, 0, 1);
        v0 = vld_a; f0 = ferr_a;
        send_a(32'h0FF0775A, 4, 0, 1'b0, 1'b1);
        expect_pulses("after_realign", v0, f0, 1, 0);

        // Realign at cnt==0 is silent
        v0 = vld_a; f0 = ferr_a;
        ifa.ser_rst = 1'b1;
        step();
        ifa.ser_rst = 1'b0;
        expect_pulses("idle_realign", v0, f0, 0, 0);

        // Realign together with a digit at cnt==3
        v0 = vld_a; f0 = ferr_a;
        send_a(32'hFFFFFFFF, 3, 0, 1'b0, 1'b0);
        send_a(32'h563412C3, 4, 0, 1'b1, 1'b1);
        expect_pulses("realign_with_digit", v0, f0, 1, 1);

        // Reset mid-word clears everything immediately
        v0 = vld_a; f0 = ferr_a;
        send_a(32'h11223344, 2, 0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("midreset_data_out_a", ifa.data_out, 0);
        chk("midreset_vld_out_a",  ifa.vld_out, 0);
        step();
        step();
        rst = 1'b1;
        expect_pulses("midreset", v0, f0, 0, 0);
        v0 = vld_a; f0 = ferr_a;
        send_a(32'h7E420981, 4, 0, 1'b0, 1'b1);
        expect_pulses("after_reset", v0, f0, 1, 0);

        // 16-bit words, 1-bit digits, three words continuously
        wb = 16'h8001;
        for (int unsigned k = 0; k < 3; k++) begin
            for (int unsigned d = 0; d < 16; d++) begin
                ifb.data_in[0] = wb[d];
                ifb.vld_in     = 1'b1;
                if (d == 15) q_b.push_back(wb);
                step();
            end
        end
        ifb.vld_in = 1'b0;
        step();
        step();
        chk("b_vld_count",  vld_b, 3);
        chk("b_ferr_count", ferr_b, 0);

        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
